// File: rtl/switch_seq_pkg.sv
// Shared types and sizing helpers for the photonic-switch toggle-slot sequencer.
package switch_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } seq_state_t;

  localparam int DEF_NCH     = 4;
  localparam int DEF_DWELL_W = 8;
  localparam int DEF_GUARD_W = 4;

  // Index width for a channel count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import switch_seq_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  localparam int IW = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [IW-1:0]  winner,
  output logic           valid
);

  int   idx;
  logic hit;

  // Scan NCH positions starting at the pointer; the first hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    hit    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx    = (int'(ptr) + i) % NCH;
      hit    = !valid && req[idx];
      winner = hit ? IW'(idx) : winner;
      valid  = valid | hit;
    end
  end

endmodule

// File: rtl/switch_sequencer.sv
// Round-robin sequencer granting one receiver channel at a time a dwell then a guard.
// Optional grant counter output enabled by defining SWITCH_SEQ_GRANT_COUNT_EN.
module switch_sequencer
  import switch_seq_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int DWELL_W = DEF_DWELL_W,
  parameter int GUARD_W = DEF_GUARD_W,
  localparam int IW     = idx_w(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [GUARD_W-1:0] guard,
  output logic [NCH-1:0]     cond,
  output logic [IW-1:0]      grant_id,
  output logic               busy,
`ifdef SWITCH_SEQ_GRANT_COUNT_EN
  output logic [15:0]        grant_cnt,
`endif
  output logic               done
);

  seq_state_t         state;
  logic [IW-1:0]      ptr;
  logic [DWELL_W-1:0] dcnt;
  logic [GUARD_W-1:0] gcnt;
  logic [IW-1:0]      winner;
  logic               valid;
  logic [IW-1:0]      ptr_next;
  logic [DWELL_W-1:0] dwell_eff;
  logic [NCH-1:0]     onehot;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (valid)
  );

  // Grant-time derived values: next pointer, clamped dwell, one-hot line.
  always_comb begin
    ptr_next  = (winner == IW'(NCH - 1)) ? '0 : winner + IW'(1);
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    onehot    = {{(NCH-1){1'b0}}, 1'b1} << winner;
  end

  // Sequencer FSM; the done cycle never arbitrates, giving guard+2 spacing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cond     <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ptr      <= '0;
      dcnt     <= '0;
      gcnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid && !done) begin
            state    <= ST_ACTIVE;
            cond     <= onehot;
            grant_id <= winner;
            busy     <= 1'b1;
            dcnt     <= dwell_eff;
            ptr      <= ptr_next;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (dcnt <= DWELL_W'(1)) begin
            cond <= '0;
            done <= 1'b1;
            dcnt <= '0;
            gcnt <= guard;
            if (guard != '0) begin
              state <= ST_GUARD;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dcnt <= dcnt - DWELL_W'(1);
          end
        end
        ST_GUARD: begin
          if (gcnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt - GUARD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cond  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SWITCH_SEQ_GRANT_COUNT_EN
  // Completed-grant total; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= 16'd0;
    end else if (done) begin
      grant_cnt <= grant_cnt + 16'd1;
    end else begin
      grant_cnt <= grant_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer with a grant-order scoreboard.
module tb_switch_sequencer;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] dwell;
  logic [3:0] guard;
  logic [3:0] cond;
  logic [1:0] grant_id;
  logic       busy;
  logic       done;
`ifdef SWITCH_SEQ_GRANT_COUNT_EN
  logic [15:0] grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int exp_q[$];
  logic       mon_en = 1'b0;
  logic [3:0] prev_cond = 4'd0;

  switch_sequencer #(.NCH(4), .DWELL_W(8), .GUARD_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .dwell    (dwell),
    .guard    (guard),
    .cond     (cond),
    .grant_id (grant_id),
    .busy     (busy),
`ifdef SWITCH_SEQ_GRANT_COUNT_EN
    .grant_cnt(grant_cnt),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each new cond-high run must match the next expected grant.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cond_onehot0", 32'($onehot0(cond)), 32'd1);
      if (cond != 4'd0 && prev_cond == 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_grant", 32'(grant_id), 32'hFFFF_FFFF);
        end else begin
          chk("sb_grant_id", 32'(grant_id), 32'(exp_q[0]));
          chk("sb_cond", 32'(cond), 32'(4'd1 << exp_q[0]));
          exp_q.delete(0);
        end
      end
    end
    prev_cond <= mon_en ? cond : 4'd0;
  end

  task automatic wait_cond(output int cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cond == 4'd0 && n < 40);
    chk("wait_cond_timeout", 32'(cond != 4'd0), 32'd1);
    cyc = cycle;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done || cond != 4'd0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(busy || done || cond != 4'd0), 32'd0);
  endtask

  task automatic hold_len(output int len);
    len = 1;
    @(negedge clk);
    while (cond != 4'd0 && len < 20) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int c_prev;
    int c_now;
    int len;

    reset = 1'b1;
    req   = 4'd0;
    dwell = 8'd3;
    guard = 4'd2;
    repeat (2) @(negedge clk);
    chk("rst_cond", 32'(cond), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef SWITCH_SEQ_GRANT_COUNT_EN
    chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single grant: dwell 3, guard 2.
    req = 4'b0010;
    exp_q.push_back(1);
    @(negedge clk);
    req = 4'd0;
    chk("t1_cond_c1", 32'(cond), 32'b0010);
    chk("t1_gid", 32'(grant_id), 32'd1);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_cond_c2", 32'(cond), 32'b0010);
    @(negedge clk);
    chk("t1_cond_c3", 32'(cond), 32'b0010);
    @(negedge clk);
    chk("t1_cond_end", 32'(cond), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_d", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_done_once", 32'(done), 32'd0);
    chk("t1_busy_g1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_g2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_off", 32'(busy), 32'd0);

    // Fresh pointer, all requesting, dwell 1 guard 0: order 0,1,2,3,0 every 3 cycles.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dwell = 8'd1;
    guard = 4'd0;
    req   = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    c_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_cond(c_now);
      if (k > 0) chk("t2_spacing", 32'(c_now - c_prev), 32'd3);
      c_prev = c_now;
    end
    req = 4'd0;
    wait_idle();

    // Pointer is 1 after grant to 0: 1001 goes to 3, then 0.
    req = 4'b1001;
    exp_q.push_back(3);
    exp_q.push_back(0);
    wait_cond(c_now);
    chk("t3_first", 32'(grant_id), 32'd3);
    wait_cond(c_now);
    chk("t3_second", 32'(grant_id), 32'd0);
    req = 4'd0;
    wait_idle();

    // dwell 0 behaves like dwell 1.
    dwell = 8'd0;
    req   = 4'b0100;
    exp_q.push_back(2);
    wait_cond(c_now);
    req = 4'd0;
    hold_len(len);
    chk("t4_dwell0_len", 32'(len), 32'd1);
    chk("t4_dwell0_done", 32'(done), 32'd1);
    wait_idle();
    dwell = 8'd1;
    req   = 4'b0100;
    exp_q.push_back(2);
    wait_cond(c_now);
    req = 4'd0;
    hold_len(len);
    chk("t4_dwell1_len", 32'(len), 32'd1);
    wait_idle();

    // Reset on the 2nd cycle of a dwell of 5.
    dwell = 8'd5;
    req   = 4'b0010;
    exp_q.push_back(1);
    wait_cond(c_now);
    req = 4'd0;
    @(negedge clk);
    chk("t5_cond_c2", 32'(cond), 32'b0010);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_cond", 32'(cond), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    req   = 4'b1010;
    exp_q.push_back(1);
    wait_cond(c_now);
    chk("t5_post_rst_gid", 32'(grant_id), 32'd1);
    req = 4'd0;
    wait_idle();

`ifdef SWITCH_SEQ_GRANT_COUNT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_cnt_zero", 32'(grant_cnt), 32'd0);
    dwell = 8'd1;
    guard = 4'd1;
    req   = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int k = 0; k < 5; k++) wait_cond(c_now);
    req = 4'd0;
    wait_idle();
    chk("t6_cnt_five", 32'(grant_cnt), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_cnt_rst", 32'(grant_cnt), 32'd0);
`endif

    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_sequencer.md
Name: switch_sequencer

Overview:
- Shares one photonic-switch toggle slot among NCH receiver channels.
- Each channel raises a request. The block grants one channel at a time, round-robin.
- For the granted channel, it drives that channel's enable_condition line high for a programmed dwell, then holds a guard interval with all lines low.
- Sits between the experiment control logic and the per-channel receiver/toggle instances.

Parameters:
- NCH, 4, number of receiver channels (2..16).
- DWELL_W, 8, width of the dwell length input.
- GUARD_W, 4, width of the guard length input.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NCH  per-channel request levels; sampled only in IDLE.
- dwell  in  DWELL_W  cycles to hold cond; latched at grant; 0 is treated as 1.
- guard  in  GUARD_W  idle cycles after each dwell; latched at end of ACTIVE.
- cond  out  NCH  one-hot enable_condition to receivers; all zero outside ACTIVE.
- grant_id  out  clog2(NCH)  index of the current or last granted channel.
- busy  out  1  high in ACTIVE and GUARD.
- done  out  1  one-cycle pulse in the first cycle after a dwell ends.

Behaviour:
- Reset values: all outputs are 0. State is IDLE. Round-robin pointer is 0. Counters are 0. Reset wins over every other event, including mid-dwell: cond is all zero from the edge at which reset is sampled.
- States: IDLE, ACTIVE, GUARD. All outputs are registered.

IDLE:
- If req != 0, pick the winner: the first set bit at or after the pointer, wrapping from NCH-1 to 0.
- At the next edge: enter ACTIVE, set cond = onehot(winner), set grant_id = winner.
- Load the dwell counter with max(dwell,1) and the pointer with (winner+1) mod NCH.
- If req == 0, stay in IDLE.

ACTIVE:
- cond is held for exactly max(dwell,1) cycles. The counter decrements each cycle.
- On the last cycle, at the next edge:
  - clear cond;
  - pulse done for one cycle;
  - latch guard;
  - go to GUARD if guard != 0, otherwise to IDLE.
- req changes during ACTIVE are ignored. A grant always runs its full dwell.

GUARD:
- Lasts exactly guard cycles with cond = 0 and busy = 1, then returns to IDLE.

Timing and counters:
- Minimum spacing from the last cond-high cycle of one grant to the first cond-high cycle of the next is guard + 2 cycles: one done/transition cycle, then one IDLE arbitration cycle.
- Counters saturate cleanly. The dwell counter never underflows; dwell = 0 behaves exactly like dwell = 1.

Invariants:
- cond is always one-hot or zero. It is never multi-hot.

Optional Feature:
- Macro: SWITCH_SEQ_GRANT_COUNT_EN.
- With the macro defined:
  - adds output grant_cnt, 16 bits, a per-block total of completed grants;
  - increments on each done pulse and wraps 0xFFFF -> 0;
  - cleared by reset.
- Without the macro: the port and counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared package switch_seq_pkg holds:
  - the state enum (IDLE, ACTIVE, GUARD);
  - default widths;
  - the NCH-to-index-width localparam helper.
- One sub-module, rr_arbiter: combinational round-robin pick from req and pointer, producing a winner index and a valid flag.
- The FSM, counters and pointer stay in switch_sequencer.

Test Plan:
- Reset, then req = 4'b0010, dwell = 3, guard = 2. Expect:
  - cond = 0010 for exactly 3 cycles, starting 1 cycle after req is sampled;
  - done pulses once;
  - busy stays high for 1 + 2 cycles after that;
  - grant_id = 1.
- req = 4'b1111 held, dwell = 1, guard = 0. Expect grant order 0, 1, 2, 3, 0, with cond-high cycles 3 cycles apart.
- req = 4'b1001 with pointer = 1 (after a grant to 0). Expect the next grant to go to 3, then 0.
- dwell = 0. Expect cond high for exactly 1 cycle, same as dwell = 1.
- Reset asserted on the 2nd cycle of a dwell of 5. Expect cond = 0, busy = 0, done = 0 on the following cycle. After release, the first grant goes to the lowest set req bit (pointer = 0).
- With SWITCH_SEQ_GRANT_COUNT_EN defined, run 5 grants. Expect grant_cnt = 5. After reset, grant_cnt = 0.
